channel_fifo: RTL

Storage end of the ac_channel handshake: a synchronous FIFO that answers the `write_valid`/`read_valid` strobes issued by generated HLS kernels and drives `write_ready`, `read_ready` and `out_data` back to them. It sits between a producer kernel's channel-write port group and a consumer kernel's channel-read port group, for example feeding words into a reduction kernel and taking its result. Each strobe is a single-cycle pulse. A popped word is presented on `out_data` the cycle after its read strobe and holds until the next pop.

---
 rtl/channel_fifo.sv | 110 +++++++++++
 1 files changed

// File: rtl/channel_fifo.sv
// channel_fifo
//   Storage end of an ac_channel handshake. A producer kernel pushes words
//   with single-cycle write_valid strobes. A consumer kernel pops them with
//   single-cycle read_valid strobes. Each popped word is registered onto
//   out_data in the cycle after its strobe and holds there until the next
//   accepted pop.
//
// Parameters
//   WIDTH       data word width
//   DEPTH       number of entries (>= 2, any value, not only powers of two)
//
// Ports
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   in_data     word to push, sampled with write_valid
//   write_valid push strobe
//   read_valid  pop strobe
//   out_data    last popped word (registered)
//   write_ready FIFO not full, forced low while rst is high
//   read_ready  FIFO not empty, forced low while rst is high
//   count       current occupancy (registered)
//   overflow    sticky: a push was attempted while full
//   underflow   sticky: a pop was attempted while empty
module channel_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       write_valid,
  input  logic                       read_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic                       write_ready,
  output logic                       read_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  // Pointers wrap explicitly because DEPTH need not be a power of two.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  assign write_ready = !rst && !full;
  assign read_ready  = !rst && !empty;

  // The readies already include rst. So strobes are ignored during reset
  // without a separate gate. Full and empty come from the registered count.
  // That prevents fall-through: a word pushed into an empty FIFO cannot be
  // popped in the same cycle. It also makes a simultaneous push and pop
  // into a plain push (when empty) or a plain pop (when full).
  assign push = write_valid && write_ready;
  assign pop  = read_valid && read_ready;

  // Storage has no reset. Only written entries are ever read back.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_data  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= bump(wr_ptr);
      end
      if (pop) begin
        out_data <= mem[rd_ptr];
        rd_ptr   <= bump(rd_ptr);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
      if (write_valid && full) begin
        overflow <= 1'b1;
      end
      if (read_valid && empty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule
